// File: rtl/spi_slave_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared state encoding and command codes for the SPI slave.
// Revision    : 1.0
// ============================================================================
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_TX        = 3'd3,
    ST_DRAIN     = 3'd4
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_shifter
// Description : MSB-first shift register with parallel load and bit counter.
// Revision    : 1.0
// ============================================================================
module spi_shifter #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          shift,
  input  logic          sin,
  output logic [W-1:0]  nxt,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // nxt is the register contents after the current shift, so a full word
  // can be taken on the same edge its last bit arrives.
  assign nxt  = {q_q[W-2:0], sin};
  assign cnt  = cnt_q;
  assign done = (cnt_q == CW'(W - 1));

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      q_d   = load_data;
      cnt_d = '0;
    end else if (shift) begin
      q_d = nxt;
      if (done) begin
        cnt_d = '0;
      end else if (cnt_q != CW'(W)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_burst.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_burst
// Description : Burst-capable SPI slave front-end for a single-port RAM.
// Revision    : 1.0
// ============================================================================
module spi_slave_burst
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16,
  parameter int BURST_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int N  = DATA_W + 2;
  localparam int RW = $clog2(N + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);

  spi_state_e        state_q, state_d;
  logic [N-1:0]      rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              rd_pend_q, rd_pend_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              rx_clr, rx_shift, tx_load, tx_shift;
  logic [N-1:0]      rx_nxt;
  logic [RW-1:0]     rx_cnt;
  logic              rx_done;
  logic [DATA_W-1:0] tx_nxt;
  logic [$clog2(DATA_W+1)-1:0] tx_cnt;
  logic              tx_done;
  logic [1:0]        rx_cmd;

  assign rx_clr = (state_q != ST_RX);
  assign rx_cmd = rx_nxt[N-1:N-2];

  spi_shifter #(.W(N)) u_rx_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (rx_clr),
    .load      (1'b0),
    .load_data ({N{1'b0}}),
    .shift     (rx_shift),
    .sin       (MOSI),
    .nxt       (rx_nxt),
    .cnt       (rx_cnt),
    .done      (rx_done)
  );

  spi_shifter #(.W(DATA_W)) u_tx_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .load      (tx_load),
    .load_data (tx_data),
    .shift     (tx_shift),
    .sin       (1'b0),
    .nxt       (tx_nxt),
    .cnt       (tx_cnt),
    .done      (tx_done)
  );

  always_comb begin
    state_d     = state_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    rd_pend_d   = rd_pend_q;
    tmo_d       = tmo_q;
    rx_shift    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (!SS_n) state_d = ST_RX;
      end

      ST_RX: begin
        if (SS_n) begin
          // Deselect between words is a clean end of frame.
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          frame_err_d = (rx_cnt != '0);
        end else begin
          rx_shift = 1'b1;
          if (rx_done) begin
            if (rx_cmd == CMD_RD_DATA) begin
              if (rd_pend_q) begin
                rx_data_d  = rx_nxt;
                rx_valid_d = 1'b1;
                rd_pend_d  = 1'b0;
                tmo_d      = '0;
                state_d    = ST_READ_WAIT;
              end else begin
                frame_err_d = 1'b1;
                state_d     = ST_DRAIN;
              end
            end else begin
              rx_data_d  = rx_nxt;
              rx_valid_d = 1'b1;
              if (rx_cmd == CMD_RD_ADDR) rd_pend_d = 1'b1;
              if (BURST_EN == 0) state_d = ST_DRAIN;
            end
          end
        end
      end

      ST_READ_WAIT: begin
        if (SS_n) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (tx_valid) begin
          tx_load = 1'b1;
          miso_d  = tx_data[DATA_W-1];
          state_d = ST_TX;
        end else if (tmo_q >= TW'(TX_TIMEOUT - 1)) begin
          tmo_d       = TW'(TX_TIMEOUT);
          frame_err_d = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_TX: begin
        if (SS_n) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (tx_done) begin
          miso_d  = 1'b0;
          state_d = (BURST_EN != 0) ? ST_RX : ST_DRAIN;
        end else begin
          tx_shift = 1'b1;
          miso_d   = tx_nxt[DATA_W-1];
        end
      end

      ST_DRAIN: begin
        miso_d = 1'b0;
        if (SS_n) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      rd_pend_q   <= rd_pend_d;
      tmo_q       <= tmo_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
